// File: rtl/regression_pkg.sv
// Shared constants for the linear-regression datapath: state encoding and
// default bank geometry used by both the sequencer and the word mux.
package regression_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int WORD_LEN   = 8;
    localparam int INPUT_SIZE = 4;
    localparam int SEL_LEN    = 2;

endpackage

// File: rtl/bounded_counter.sv
// Up-counter that wraps from max back to zero; at_max flags the last value
// so the owner can detect the final write / final word.
module bounded_counter #(
    parameter int width = 2,
    parameter int max   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] count,
    output logic             at_max
);

    assign at_max = (count == width'(max));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sample_bank_sequencer.sv
// Serially loads a word bank, then walks the mux select across it under a
// valid/ready handshake and pulses done when the last word is taken.
module sample_bank_sequencer
    import regression_pkg::*;
#(
    parameter int word_len   = WORD_LEN,
    parameter int input_size = INPUT_SIZE,
    parameter int sel_len    = SEL_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [word_len-1:0]            wr_data,
    input  logic                           clear,
    input  logic                           start,
    input  logic                           out_ready,
    output logic [word_len*input_size-1:0] bank_flat,
    output logic [sel_len-1:0]             sel,
    output logic                           out_valid,
    output logic                           full,
    output logic                           busy,
    output logic                           done,
    output logic                           ovf
);

    localparam int PTR_W = (input_size > 1) ? $clog2(input_size) : 1;

    if (input_size > (2 ** sel_len)) begin : g_sel_too_narrow
        $error("sample_bank_sequencer: input_size exceeds 2**sel_len");
    end

    state_t              state, state_nxt;
    logic [word_len-1:0] bank [input_size];
    logic [PTR_W-1:0]    wr_ptr;
    logic                ptr_at_max, ptr_inc, ptr_clr;
    logic                sel_at_max, sel_inc;
    logic                wr_do, full_nxt, ovf_nxt;

    bounded_counter #(.width(PTR_W), .max(input_size - 1)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (ptr_inc),
        .clr    (ptr_clr),
        .count  (wr_ptr),
        .at_max (ptr_at_max)
    );

    // Wrap-to-zero on the last accept leaves sel at 0 for the next pass.
    bounded_counter #(.width(sel_len), .max(input_size - 1)) u_sel (
        .clk    (clk),
        .rst    (rst),
        .inc    (sel_inc),
        .clr    (1'b0),
        .count  (sel),
        .at_max (sel_at_max)
    );

    always_comb begin
        state_nxt = state;
        wr_do     = 1'b0;
        ptr_inc   = 1'b0;
        ptr_clr   = 1'b0;
        sel_inc   = 1'b0;
        full_nxt  = full;
        ovf_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                // clear shadows both a same-cycle write and a same-cycle start
                if (clear) begin
                    ptr_clr  = 1'b1;
                    full_nxt = 1'b0;
                end else begin
                    if (wr_en) begin
                        if (full) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            wr_do   = 1'b1;
                            ptr_inc = 1'b1;
                            if (ptr_at_max) full_nxt = 1'b1;
                        end
                    end
                    if (start && full) state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ovf_nxt = wr_en;
                // out_valid is always high here, so out_ready alone is an accept
                if (out_ready) begin
                    sel_inc = 1'b1;
                    if (sel_at_max) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ovf_nxt   = wr_en;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            full  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            full  <= full_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < input_size; i++) bank[i] <= '0;
        end else if (wr_do) begin
            bank[wr_ptr] <= wr_data;
        end
    end

    // Word 0 sits in the MSBs of the bus.
    for (genvar i = 0; i < input_size; i++) begin : g_pack
        assign bank_flat[word_len*(input_size-i)-1 -: word_len] = bank[i];
    end

    assign out_valid = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_sample_bank_sequencer.sv
// Scoreboarded bench: a 4-word instance exercises load/stream/priority/reset,
// a 3-word instance covers the non-power-of-two select range and replay.
module tb_sample_bank_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_wr_en, a_clear, a_start, a_ready;
    logic [7:0]  a_wr_data;
    logic [31:0] a_flat;
    logic [1:0]  a_sel;
    logic        a_valid, a_full, a_busy, a_done, a_ovf;

    logic        b_wr_en, b_clear, b_start, b_ready;
    logic [7:0]  b_wr_data;
    logic [23:0] b_flat;
    logic [1:0]  b_sel;
    logic        b_valid, b_full, b_busy, b_done, b_ovf;

    sample_bank_sequencer #(.word_len(8), .input_size(4), .sel_len(2)) dut_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .clear(a_clear),
        .start(a_start), .out_ready(a_ready), .bank_flat(a_flat), .sel(a_sel),
        .out_valid(a_valid), .full(a_full), .busy(a_busy), .done(a_done), .ovf(a_ovf)
    );

    sample_bank_sequencer #(.word_len(8), .input_size(3), .sel_len(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .clear(b_clear),
        .start(b_start), .out_ready(b_ready), .bank_flat(b_flat), .sel(b_sel),
        .out_valid(b_valid), .full(b_full), .busy(b_busy), .done(b_done), .ovf(b_ovf)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] data;
        int         idx;
        bit         last;
    } exp_t;

    exp_t       qa[$], qb[$];
    exp_t       ea, eb;
    logic [7:0] ma[4], mb[3];
    int         cnt_a, cnt_b, acc_a;
    bit         due_a, due_b, hold_a;
    logic [1:0] hsel;
    logic [7:0] hword;

    function automatic logic [31:0] pack_a();
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[23:0], ma[i]};
        return r;
    endfunction

    function automatic logic [7:0] word_a(input logic [31:0] f, input logic [1:0] s);
        logic [31:0] t = f >> (8 * (3 - int'(s)));
        return t[7:0];
    endfunction

    function automatic logic [7:0] word_b(input logic [23:0] f, input logic [1:0] s);
        logic [23:0] t = f >> (8 * (2 - int'(s)));
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: done timing, stall stability, and in-order word delivery.
    always @(negedge clk) begin
        if (rst) begin
            hold_a = 1'b0;
            due_a  = 1'b0;
        end else begin
            chk("a_done", a_done, due_a);
            due_a = 1'b0;
            if (hold_a && a_valid) begin
                chk("a_hold_sel", a_sel, hsel);
                chk("a_hold_word", word_a(a_flat, a_sel), hword);
            end
            hold_a = a_valid && !a_ready;
            hsel   = a_sel;
            hword  = word_a(a_flat, a_sel);
            if (a_valid && a_ready) begin
                acc_a++;
                chk("a_word_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_sel", a_sel, ea.idx);
                    chk("a_word", word_a(a_flat, a_sel), ea.data);
                    due_a = ea.last;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            due_b = 1'b0;
        end else begin
            chk("b_done", b_done, due_b);
            due_b = 1'b0;
            if (b_valid) chk("b_sel_range", b_sel <= 2'd2, 1);
            if (b_valid && b_ready) begin
                chk("b_word_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_sel", b_sel, eb.idx);
                    chk("b_word", word_b(b_flat, b_sel), eb.data);
                    due_b = eb.last;
                end
            end
        end
    end

    task automatic a_write(input logic [7:0] d);
        bit eo = (cnt_a == 4);
        a_wr_en = 1'b1;
        a_wr_data = d;
        if (!eo) begin
            ma[cnt_a] = d;
            cnt_a++;
        end
        tick();
        a_wr_en = 1'b0;
        @(negedge clk);
        chk("a_ovf", a_ovf, eo);
        chk("a_full", a_full, cnt_a == 4);
        chk("a_flat", a_flat, pack_a());
    endtask

    // Always clears; optionally with a same-cycle start and/or write.
    task automatic a_clear_with(input bit s, input bit w, input logic [7:0] d);
        a_clear = 1'b1;
        a_start = s;
        a_wr_en = w;
        a_wr_data = d;
        cnt_a = 0;
        tick();
        a_clear = 1'b0;
        a_start = 1'b0;
        a_wr_en = 1'b0;
        @(negedge clk);
        chk("a_clr_full", a_full, 0);
        chk("a_clr_busy", a_busy, 0);
        chk("a_clr_ovf", a_ovf, 0);
        chk("a_clr_flat", a_flat, pack_a());
    endtask

    // mask bit k = out_ready on the k-th cycle after start (1 beyond bit 31).
    task automatic a_stream(input logic [31:0] mask);
        int k = 0;
        int ones = 0;
        int exp_k = -1;
        bit go = (cnt_a == 4);
        if (go) begin
            for (int i = 0; i < 4; i++) qa.push_back('{ma[i], i, i == 3});
            for (int j = 0; j < 64 && exp_k < 0; j++) begin
                if (j >= 32 || mask[j]) ones++;
                if (ones == 4) exp_k = j + 1;
            end
        end
        a_ready = mask[0];
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        if (go) begin
            while (k < 200) begin
                @(negedge clk);
                if (a_done) break;
                tick();
                k++;
                a_ready = (k < 32) ? mask[k] : 1'b1;
            end
            chk("a_done_cycle", k, exp_k);
            chk("a_drained", qa.size(), 0);
            tick();
            @(negedge clk);
            chk("a_post_busy", a_busy, 0);
            chk("a_post_full", a_full, 1);
            chk("a_post_valid", a_valid, 0);
            chk("a_post_sel", a_sel, 0);
        end else begin
            repeat (4) begin
                @(negedge clk);
                chk("a_nostart_busy", a_busy, 0);
                chk("a_nostart_valid", a_valid, 0);
            end
        end
        a_ready = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] d);
        bit eo = (cnt_b == 3);
        b_wr_en = 1'b1;
        b_wr_data = d;
        if (!eo) begin
            mb[cnt_b] = d;
            cnt_b++;
        end
        tick();
        b_wr_en = 1'b0;
        @(negedge clk);
        chk("b_ovf", b_ovf, eo);
        chk("b_full", b_full, cnt_b == 3);
    endtask

    task automatic b_stream();
        int k = 0;
        for (int i = 0; i < 3; i++) qb.push_back('{mb[i], i, i == 2});
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            if (b_done) break;
            tick();
            k++;
            b_ready = 1'($urandom_range(0, 1));
        end
        chk("b_drained", qb.size(), 0);
        chk("b_done_seen", b_done, 1);
        tick();
        @(negedge clk);
        chk("b_post_busy", b_busy, 0);
        chk("b_post_full", b_full, 1);
        b_ready = 1'b0;
    endtask

    initial begin
        int acc0;
        int k;
        {a_wr_en, a_clear, a_start, a_ready, a_wr_data} = '0;
        {b_wr_en, b_clear, b_start, b_ready, b_wr_data} = '0;
        for (int i = 0; i < 4; i++) ma[i] = '0;
        for (int i = 0; i < 3; i++) mb[i] = '0;
        cnt_a = 0; cnt_b = 0; acc_a = 0;

        @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_sel", a_sel, 0);
        chk("rst_full", a_full, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_flat", a_flat, 0);
        chk("rst_b_flat", b_flat, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        a_write(8'h11); a_write(8'h22); a_write(8'h33); a_write(8'h44);
        chk("a_packing", a_flat, 32'h11223344);
        a_write(8'h55);
        chk("a_ovf_bank_kept", a_flat, 32'h11223344);

        a_stream(32'hFFFF_FFFF);
        acc0 = acc_a;
        a_stream(32'hFFFF_FFF1);
        chk("a_bp_accepted", acc_a - acc0, 4);
        repeat (3) a_stream($urandom() | 32'hFFFF_0000);

        a_clear_with(1'b1, 1'b0, 8'h00);
        a_stream(32'hFFFF_FFFF);
        a_clear_with(1'b0, 1'b1, 8'hAA);

        repeat (2) begin
            a_clear_with(1'b0, 1'b0, 8'h00);
            repeat (4) a_write(8'($urandom()));
            a_stream($urandom() | 32'hFF00_0000);
        end

        // Async reset while sel==2 mid-stream.
        a_ready = 1'b1;
        a_start = 1'b1;
        for (int i = 0; i < 4; i++) qa.push_back('{ma[i], i, i == 3});
        tick();
        a_start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (a_sel != 2'd2 && k < 10);
        chk("a_reached_sel2", a_sel, 2);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_sel", a_sel, 0);
        chk("mid_rst_full", a_full, 0);
        chk("mid_rst_flat", a_flat, 0);
        chk("mid_rst_busy", a_busy, 0);
        for (int i = 0; i < 4; i++) ma[i] = '0;
        for (int i = 0; i < 3; i++) mb[i] = '0;
        cnt_a = 0; cnt_b = 0;
        qa.delete(); qb.delete();
        due_a = 1'b0; hold_a = 1'b0;
        a_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (4) a_write(8'($urandom()));
        a_stream(32'hFFFF_FFFF);

        repeat (3) b_write(8'($urandom()));
        b_write(8'hEE);
        b_stream();
        b_stream();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
